// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I memory-access stage.
//   OPC_LOAD / OPC_STORE : major opcodes of memory instructions
//   F3_*                 : func3 encodings selecting access size / signedness
//   mem_state_t          : memory-stage FSM states
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/rv32i_mem_top_if.sv
// Data-memory request/acknowledge bus.
//   master : the memory stage (drives req/we/be/addr/wdata, samples rdata/ack)
//   slave  : the data memory
// dmem_req is held with stable attributes until dmem_ack pulses for one cycle.
interface rv32i_mem_top_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/rv32i_load_align.sv
// Combinational load formatter: picks the addressed byte/half lane out of a
// 32-bit read word and sign- or zero-extends it.
//   rdata : raw word from data memory
//   addr  : low two bits of the effective address
//   func3 : load func3 (B/H/W/BU/HU; anything else passes rdata through)
//   data  : extended load result
module rv32i_load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  func3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr, 3'b000} +: 8];
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (func3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_mem_top.sv
// RV32I memory-access pipeline stage (between execute and writeback).
// Non-memory ops pass through with one cycle of latency. Loads/stores issue a
// registered request on the dmem bus and stall upstream until ack or timeout.
//   clk, reset            : clock, asynchronous active-low reset
//   valid_in .. wb_reg_in : execute-stage outputs (held by upstream on stall)
//   stall_out             : upstream must hold this cycle
//   dmem                  : data-memory bus (master side)
//   valid_out .. bus_err  : writeback-stage inputs, bus_err = timeout pulse
//   df_mem_*              : forwarding/hazard information for decode
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned H/W accesses complete
// in one cycle without touching memory and pulse the extra misalign_err port.
// Without it, address bits below the access size are silently ignored.
module rv32i_mem_top
    import rv32i_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] pc_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_reg_in,
    output logic        stall_out,
    rv32i_mem_top_if.master dmem,
    output logic        valid_out,
    output logic [31:0] wb_data_out,
    output logic [31:0] iw_out,
    output logic [31:0] pc_out,
    output logic        wb_en_out,
    output logic [4:0]  wb_reg_out,
    output logic        bus_err,
    output logic        df_mem_enable,
    output logic [4:0]  df_mem_reg,
    output logic [31:0] df_mem_data,
    output logic        df_mem_load_pending
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    mem_state_t  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ld_q, ld_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;
    logic        valid_out_q, valid_out_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] iw_q, iw_d;
    logic [31:0] pc_q, pc_d;
    logic        wb_en_q, wb_en_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic        bus_err_q, bus_err_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        merr_q, merr_d;
`endif

    // ---- decode of the instruction presented by execute ----
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        is_ld, is_st, misalign, mem_go;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    assign opc   = iw_in[6:0];
    assign f3    = iw_in[14:12];
    assign is_ld = (opc == OPC_LOAD)  && (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign is_st = (opc == OPC_STORE) && (f3 inside {F3_B, F3_H, F3_W});

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = (is_ld || is_st) &&
                      ((((f3 == F3_H) || (f3 == F3_HU)) && alu_in[0]) ||
                       ((f3 == F3_W) && (alu_in[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign mem_go = valid_in && (is_ld || is_st) && !misalign;

    // Lane enables and lane-replicated store data; loads reuse the same enables.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = rs2_data_in;
        case (f3)
            F3_B, F3_BU: begin
                be_c    = 4'b0001 << alu_in[1:0];
                wdata_c = {4{rs2_data_in[7:0]}};
            end
            F3_H, F3_HU: begin
                be_c    = alu_in[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{rs2_data_in[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = rs2_data_in;
            end
        endcase
    end

    // ---- access tracking ----
    logic        in_access, ack_done, timeout, stall_c, df_ok;
    logic [31:0] ld_data;

    assign in_access = (state_q == ACCESS);
    assign ack_done  = in_access && dmem.dmem_ack;
    assign timeout   = in_access && !dmem.dmem_ack && (wait_cnt_q == WAIT_LAST);
    assign stall_c   = in_access ? (!dmem.dmem_ack && !timeout) : mem_go;

    rv32i_load_align u_align (
        .rdata (dmem.dmem_rdata),
        .addr  (lo_q),
        .func3 (f3_q),
        .data  (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ld_d        = ld_q;
        f3_d        = f3_q;
        lo_d        = lo_q;
        valid_out_d = 1'b0;
        wb_data_d   = wb_data_q;
        iw_d        = iw_q;
        pc_d        = pc_q;
        wb_en_d     = 1'b0;
        wb_reg_d    = wb_reg_q;
        bus_err_d   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        merr_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mem_go) begin
                    state_d    = ACCESS;
                    wait_cnt_d = 8'd0;
                    req_d      = 1'b1;
                    we_d       = is_st;
                    be_d       = be_c;
                    addr_d     = {alu_in[31:2], 2'b00};
                    wdata_d    = wdata_c;
                    ld_d       = is_ld;
                    f3_d       = f3;
                    lo_d       = alu_in[1:0];
                end else if (valid_in) begin
                    // Pass-through (or trapped misaligned access) retires now.
                    valid_out_d = 1'b1;
                    wb_data_d   = misalign ? 32'h0 : alu_in;
                    wb_en_d     = wb_en_in && (wb_reg_in != 5'd0) && !misalign;
                    iw_d        = iw_in;
                    pc_d        = pc_in;
                    wb_reg_d    = wb_reg_in;
`ifdef MEM_MISALIGN_TRAP_EN
                    merr_d      = misalign;
`endif
                end
            end
            ACCESS: begin
                // Tags come straight from the inputs: upstream holds them while stalled.
                if (ack_done || timeout) begin
                    state_d     = IDLE;
                    req_d       = 1'b0;
                    valid_out_d = 1'b1;
                    iw_d        = iw_in;
                    pc_d        = pc_in;
                    wb_reg_d    = wb_reg_in;
                    if (ack_done) begin
                        wb_data_d = ld_q ? ld_data : alu_in;
                        wb_en_d   = ld_q && wb_en_in && (wb_reg_in != 5'd0);
                    end else begin
                        wb_data_d = 32'h0;
                        bus_err_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 8'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= 4'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            ld_q        <= 1'b0;
            f3_q        <= 3'b000;
            lo_q        <= 2'b00;
            valid_out_q <= 1'b0;
            wb_data_q   <= 32'h0;
            iw_q        <= 32'h0;
            pc_q        <= 32'h0;
            wb_en_q     <= 1'b0;
            wb_reg_q    <= 5'd0;
            bus_err_q   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            merr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ld_q        <= ld_d;
            f3_q        <= f3_d;
            lo_q        <= lo_d;
            valid_out_q <= valid_out_d;
            wb_data_q   <= wb_data_d;
            iw_q        <= iw_d;
            pc_q        <= pc_d;
            wb_en_q     <= wb_en_d;
            wb_reg_q    <= wb_reg_d;
            bus_err_q   <= bus_err_d;
`ifdef MEM_MISALIGN_TRAP_EN
            merr_q      <= merr_d;
`endif
        end
    end

    // Combinational outputs are forced low during reset so everything reads 0.
    assign stall_out = reset && stall_c;

    // Only results that writeback will actually commit are forwarded.
    assign df_ok = in_access ? (ld_q && ack_done) : !misalign;
    assign df_mem_enable = reset && valid_in && wb_en_in && !stall_c &&
                           (wb_reg_in != 5'd0) && df_ok;
    assign df_mem_reg  = reset ? wb_reg_in : 5'd0;
    assign df_mem_data = !reset ? 32'h0 : (in_access ? ld_data : alu_in);
    assign df_mem_load_pending = reset &&
        ((in_access && ld_q && !dmem.dmem_ack && !timeout) ||
         (!in_access && mem_go && is_ld));

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign valid_out   = valid_out_q;
    assign wb_data_out = wb_data_q;
    assign iw_out      = iw_q;
    assign pc_out      = pc_q;
    assign wb_en_out   = wb_en_q;
    assign wb_reg_out  = wb_reg_q;
    assign bus_err     = bus_err_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_err = merr_q;
`endif

endmodule

// File: tb/tb_rv32i_mem_top.sv
// Scoreboard bench for rv32i_mem_top: the driver issues instructions and
// pushes expected bus requests / writeback results; a memory responder and an
// output monitor pop and compare independently.
module tb_rv32i_mem_top;

    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_in, rs2_data_in, iw_in, pc_in;
    logic        wb_en_in;
    logic [4:0]  wb_reg_in;
    logic        stall_out, valid_out, wb_en_out, bus_err;
    logic [31:0] wb_data_out, iw_out, pc_out, df_mem_data;
    logic [4:0]  wb_reg_out, df_mem_reg;
    logic        df_mem_enable, df_mem_load_pending;
    logic        misalign_err;

    rv32i_mem_top_if dmem ();

    always #5 clk = ~clk;

    rv32i_mem_top #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_in(alu_in),
        .rs2_data_in(rs2_data_in), .iw_in(iw_in), .pc_in(pc_in),
        .wb_en_in(wb_en_in), .wb_reg_in(wb_reg_in), .stall_out(stall_out),
        .dmem(dmem), .valid_out(valid_out), .wb_data_out(wb_data_out),
        .iw_out(iw_out), .pc_out(pc_out), .wb_en_out(wb_en_out),
        .wb_reg_out(wb_reg_out), .bus_err(bus_err),
        .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg),
        .df_mem_data(df_mem_data), .df_mem_load_pending(df_mem_load_pending)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_err(misalign_err)
`endif
    );

`ifndef MEM_MISALIGN_TRAP_EN
    assign misalign_err = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic [31:0] data;
        bit          chk_data;
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] iw, pc;
        logic        berr, merr;
    } exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr, wdata;
        bit          chk_wdata;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int   lat_q[$];
    logic [31:0] mem [bit [31:0]];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        bit   busy = 0;
        int   cnt = 0, lat = 0;
        req_t r;
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            dmem.dmem_ack   = 1'b0;
            dmem.dmem_rdata = $urandom();
            if (reset !== 1'b1) begin
                busy = 0;
                continue;
            end
            if (dmem.dmem_req && !busy) begin
                busy = 1;
                cnt  = 0;
                if (req_q.size() == 0 || lat_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_req: got req addr %h expected none", dmem.dmem_addr);
                    lat = 0;
                end else begin
                    r   = req_q.pop_front();
                    lat = lat_q.pop_front();
                    check("req_we",   32'(dmem.dmem_we),   32'(r.we));
                    check("req_be",   32'(dmem.dmem_be),   32'(r.be));
                    check("req_addr", dmem.dmem_addr,      r.addr);
                    if (r.chk_wdata) check("req_wdata", dmem.dmem_wdata, r.wdata);
                end
            end else if (busy && !dmem.dmem_req) begin
                n_chk++; n_fail++;
                $display("FAIL req_held: got req 0 expected 1 while waiting");
                busy = 0;
            end
            if (busy) begin
                if (cnt == lat && lat < MAX_WAIT) begin
                    dmem.dmem_ack   = 1'b1;
                    dmem.dmem_rdata = mem_word(dmem.dmem_addr);
                    busy = 0;
                end else if (cnt == MAX_WAIT - 1) begin
                    busy = 0;
                end
                cnt++;
            end
        end
    end

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1) begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_valid_out: got pc %h expected no result", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_data) check("wb_data", wb_data_out, e.data);
                    check("wb_en",   32'(wb_en_out),  32'(e.wb_en));
                    check("wb_reg",  32'(wb_reg_out), 32'(e.rd));
                    check("iw_out",  iw_out, e.iw);
                    check("pc_out",  pc_out, e.pc);
                    check("bus_err", 32'(bus_err),    32'(e.berr));
`ifdef MEM_MISALIGN_TRAP_EN
                    check("misalign_err", 32'(misalign_err), 32'(e.merr));
`endif
                end
            end else if (bus_err || misalign_err) begin
                n_chk++; n_fail++;
                $display("FAIL err_without_valid: got err pulse expected none");
            end
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic issue(input logic [31:0] iw, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rs2,
                         input logic wen, input logic [4:0] rd, input int lat);
        logic [6:0]  opc = iw[6:0];
        logic [2:0]  f3  = iw[14:12];
        bit          ld, st, mis, mem_op;
        int          nbytes, off, m, exp_stall, nst;
        logic [31:0] v;
        exp_t        e;
        req_t        r;

        ld = (opc == 7'b0000011) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        st = (opc == 7'b0100011) && (f3 <= 3'd2);
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis = 0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = (ld || st) && ((alu % nbytes) != 0);
`endif
        mem_op = (ld || st) && !mis;
        off = (nbytes == 4) ? 0 : (nbytes == 2) ? (alu[1] ? 2 : 0) : int'(alu[1:0]);

        e.iw = iw; e.pc = pc; e.rd = rd; e.berr = 0; e.merr = mis;
        e.chk_data = 1; e.data = alu; e.wb_en = wen && (rd != 0);
        exp_stall = 0;
        if (mem_op) begin
            m = ((1 << nbytes) - 1) << off;
            r.we = st; r.be = m[3:0]; r.addr = alu & 32'hFFFF_FFFC;
            r.wdata = (nbytes == 1) ? rs2[7:0] * 32'h01010101 :
                      (nbytes == 2) ? rs2[15:0] * 32'h00010001 : rs2;
            r.chk_wdata = st;
            req_q.push_back(r);
            lat_q.push_back(lat);
            if (lat >= MAX_WAIT) begin
                e.data = 0; e.wb_en = 0; e.berr = 1;
                exp_stall = MAX_WAIT;
            end else begin
                exp_stall = lat + 1;
                if (st) begin
                    e.chk_data = 0; e.wb_en = 0;
                end else begin
                    v = mem_word(alu & 32'hFFFF_FFFC) >> (8 * off);
                    if (nbytes == 1) begin
                        v = v & 32'hFF;
                        if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
                    end else if (nbytes == 2) begin
                        v = v & 32'hFFFF;
                        if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
                    end
                    e.data = v;
                end
            end
        end else if (mis) begin
            e.data = 0; e.wb_en = 0;
        end
        exp_q.push_back(e);

        valid_in = 1; iw_in = iw; pc_in = pc; alu_in = alu;
        rs2_data_in = rs2; wb_en_in = wen; wb_reg_in = rd;

        nst = 0;
        @(negedge clk);
        if (!(ld || st)) begin
            check("df_enable", 32'(df_mem_enable), 32'(wen && rd != 0));
            if (wen && rd != 0) begin
                check("df_data", df_mem_data, alu);
                check("df_reg",  32'(df_mem_reg), 32'(rd));
            end
        end else if (mem_op && ld) begin
            check("df_load_pending", 32'(df_mem_load_pending), 32'd1);
            check("df_enable_ld",    32'(df_mem_enable),       32'd0);
        end
        while (stall_out) begin
            nst++;
            if (nst > 4 * MAX_WAIT) begin
                n_chk++; n_fail++;
                $display("FAIL stall_bound: got stall > %0d cycles expected release", 4 * MAX_WAIT);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        check("stall_cycles", 32'(nst), 32'(exp_stall));
        valid_in = 0;
    endtask

    task automatic idle(input int n);
        valid_in = 0;
        iw_in = $urandom(); alu_in = $urandom();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] mk_iw(logic [6:0] opc, logic [2:0] f3, logic [4:0] rd);
        logic [31:0] r = $urandom();
        return {r[31:15], f3, rd, opc};
    endfunction

    initial begin
        int p, kind, lat;
        logic [2:0] f3;
        logic [6:0] opc;
        logic [4:0] rd;
        logic [31:0] r;

        reset = 0; valid_in = 1; wb_en_in = 1; wb_reg_in = 5'd3;
        iw_in = {17'h0, 3'b010, 5'd3, 7'b0000011}; alu_in = 32'h100;
        pc_in = 0; rs2_data_in = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", 32'(valid_out), 0);
        check("rst_dmem_req",  32'(dmem.dmem_req), 0);
        check("rst_stall",     32'(stall_out), 0);
        check("rst_wb_en",     32'(wb_en_out), 0);
        check("rst_wb_data",   wb_data_out, 0);
        check("rst_bus_err",   32'(bus_err), 0);
        check("rst_df_pend",   32'(df_mem_load_pending), 0);
        check("rst_df_en",     32'(df_mem_enable), 0);
        check("rst_be",        32'(dmem.dmem_be), 0);
        valid_in = 0;
        @(posedge clk); #3 reset = 1;
        @(posedge clk); #1;

        mem[32'h100] = 32'h8012_3456;
        issue({7'h0, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011}, 32'h1000, 32'h1234, 0, 1, 5'd5, 0);
        issue({12'h0, 5'd1, 3'b000, 5'd6, 7'b0000011}, 32'h1004, 32'h103, 0, 1, 5'd6, 3);
        issue({12'h0, 5'd1, 3'b100, 5'd7, 7'b0000011}, 32'h1008, 32'h103, 0, 1, 5'd7, 0);
        issue({7'h0, 5'd2, 5'd1, 3'b001, 5'd0, 7'b0100011}, 32'h100C, 32'h202, 32'hABCD_1234, 0, 5'd0, 1);
        issue({12'h0, 5'd1, 3'b010, 5'd8, 7'b0000011}, 32'h1010, 32'h400, 0, 1, 5'd8, 100);
        issue({12'h0, 5'd1, 3'b010, 5'd9, 7'b0000011}, 32'h1014, 32'h101, 0, 1, 5'd9, 0);
        issue({12'h0, 5'd1, 3'b010, 5'd10, 7'b0000011}, 32'h1018, 32'h500, 0, 1, 5'd10, MAX_WAIT - 1);
        issue({12'h0, 5'd1, 3'b001, 5'd0, 7'b0000011}, 32'h101C, 32'h102, 0, 1, 5'd0, 2);
        idle(2);

        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                opc = $urandom_range(0, 1) ? 7'b0110011 : 7'b0010011;
                f3  = 3'($urandom_range(0, 7));
            end else if (kind < 7) begin
                opc = 7'b0000011;
                r = $urandom_range(0, 7);
                f3 = (r == 0) ? 3'($urandom_range(6, 7)) : 3'(r == 1 ? 0 : r == 2 ? 1 : r == 3 ? 2 : r == 4 ? 4 : 5);
            end else begin
                opc = 7'b0100011;
                f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            end
            p = $urandom_range(0, 15);
            lat = (p < 11) ? $urandom_range(0, 3) : (p < 13) ? MAX_WAIT - 1 :
                  (p < 14) ? MAX_WAIT - 2 : MAX_WAIT + 3;
            rd = 5'($urandom_range(0, 31));
            issue(mk_iw(opc, f3, rd), $urandom(), $urandom(), $urandom(),
                  $urandom_range(0, 3) != 0, rd, lat);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        // Reset during the second ACCESS cycle of a never-acked LW.
        begin
            req_t rq;
            rq.we = 0; rq.be = 4'hF; rq.addr = 32'h600; rq.wdata = 0; rq.chk_wdata = 0;
            req_q.push_back(rq);
            lat_q.push_back(1000);
            valid_in = 1; iw_in = {12'h0, 5'd1, 3'b010, 5'd11, 7'b0000011};
            alu_in = 32'h600; wb_en_in = 1; wb_reg_in = 5'd11;
            @(posedge clk); #1;
            @(posedge clk); #1;
            check("mid_req_active", 32'(dmem.dmem_req), 1);
            reset = 0;
            #1;
            check("mid_rst_req",   32'(dmem.dmem_req), 0);
            check("mid_rst_stall", 32'(stall_out), 0);
            check("mid_rst_valid", 32'(valid_out), 0);
            check("mid_rst_pend",  32'(df_mem_load_pending), 0);
            valid_in = 0;
            @(posedge clk); #3 reset = 1;
            @(posedge clk); #1;
            issue({12'h0, 5'd1, 3'b010, 5'd12, 7'b0000011}, 32'h2000, 32'h700, 0, 1, 5'd12, 1);
        end

        idle(5);
        check("exp_q_drained", 32'(exp_q.size()), 0);
        check("req_q_drained", 32'(req_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no end of test expected finish within 60000 cycles");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv32i_mem_top.md
Name: rv32i_mem_top

Overview:
Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of writeback.
- Receives the ALU result, which serves as the effective address for loads and stores, plus the store data, IW, PC and writeback tags.
- Runs load/store transactions on a variable-latency data-memory req/ack port, stalling upstream while a transaction is in flight.
- Formats load data (lane select, sign/zero extension) and forwards its result for hazard resolution.

Parameters:
MAX_WAIT, 16, ACCESS cycles without ack before timeout (2..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset; asserting it (low) clears all state immediately
valid_in  in  1  execute-stage output holds a real instruction
alu_in  in  32  ALU result / effective address
rs2_data_in  in  32  store data (execute stage passes rs2 through)
iw_in  in  32  instruction word
pc_in  in  32  program counter
wb_en_in  in  1  writeback enable
wb_reg_in  in  5  writeback register
stall_out  out  1  upstream must hold its outputs this cycle
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = store
dmem_be  out  4  byte enables
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read data, valid when dmem_ack=1
dmem_ack  in  1  single-cycle completion strobe
valid_out  out  1  writeback-stage inputs are valid
wb_data_out  out  32  result to writeback
iw_out, pc_out  out  32  passed through
wb_en_out  out  1  passed through, qualified
wb_reg_out  out  5  passed through
bus_err  out  1  one-cycle pulse on timeout
df_mem_enable  out  1  forwarding: valid write this cycle
df_mem_reg  out  5  forwarding register
df_mem_data  out  32  forwarding data
df_mem_load_pending  out  1  load in flight; decode must stall on a match

Behaviour:
Reset (reset=0): state IDLE; all outputs and counters are 0, including dmem_req. Any in-flight request is abandoned, and memory must tolerate that.

Decode: LOAD opcode is 0000011, STORE opcode is 0100011. func3 selects the access:
- 000 B, 001 H, 010 W
- 100 BU, 101 HU (loads only)
- other func3 values are treated as non-memory pass-through.

State machine (states IDLE, ACCESS):
- IDLE, non-memory op: 1-cycle latency; next edge captures wb_data_out=alu_in and passes tags through.
- IDLE, memory op with valid_in=1: stall_out=1 combinationally. At the next edge the stage registers addr/we/be/wdata, sets dmem_req=1, clears wait_cnt and moves to ACCESS. valid_out=0 (bubble).
- ACCESS: dmem_req, addr, we, be and wdata are held stable.
  - stall_out = !dmem_ack && !timeout.
  - wait_cnt increments each cycle without ack.
  - At the edge where dmem_ack=1: dmem_req←0, result registered, valid_out←1, state→IDLE. The upstream instruction advances on the same edge.
- Timeout (wait_cnt==MAX_WAIT-1 and no ack): completes as on ack, but wb_en_out←0, wb_data_out←0 and bus_err pulses for 1 cycle.
- A late ack arriving in IDLE is ignored.
- Minimum memory-op latency is 2 cycles (IDLE→ACCESS with same-cycle ack).

Stores:
- wb_en_out forced to 0.
- SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
- SH: wdata={2{rs2[15:0]}}, be=addr[1]?1100:0011.
- SW: be=1111.

Loads:
- Lane selected by addr[1:0] (byte) or addr[1] (half).
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes dmem_rdata unchanged.

Writeback qualification: wb_en_out=0 whenever wb_reg_in==0 or valid_out=0.

Forwarding outputs:
- df_mem_enable = valid_in & wb_en_in & !stall_out & (wb_reg_in!=0).
- df_mem_data is alu_in for non-memory ops, or the formatted dmem_rdata in the ack cycle.
- df_mem_load_pending = (state==ACCESS or memory op waiting in IDLE) & load. While it is set, df_mem_reg is valid and df_mem_enable=0.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: misaligned accesses are detected (H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠0).
  - The access completes in 1 cycle with no dmem_req and no stall.
  - misalign_err (extra 1-bit output, registered pulse) is asserted.
  - wb_en_out←0.
- Undefined: no misalign_err port; low address bits beyond the access size are ignored (silent alignment).

Decomposition:
- Package rv32i_pkg holds:
  - OPC_LOAD and OPC_STORE constants
  - F3_B/H/W/BU/HU constants
  - typedef enum logic [0:0] mem_state_t {IDLE, ACCESS}
- Sub-module rv32i_load_align is purely combinational: inputs rdata, addr[1:0], func3; output 32-bit extended data. It is also reused by the forwarding path.

Test Plan:
1. ADD result 0x0000_1234, wb_reg=5 → next edge wb_data_out=0x1234, wb_en_out=1, no stall, dmem_req never asserted.
2. LB at addr 0x103, rdata 0x80xx_xxxx, ack 3 cycles after req → stall 4 cycles, wb_data_out=0xFFFF_FF80; LBU gives 0x0000_0080.
3. SH at addr 0x202, rs2=0xABCD_1234 → dmem_be=1100, dmem_wdata=0x1234_1234, dmem_addr=0x200, wb_en_out=0.
4. LW with dmem_ack never asserted, MAX_WAIT=16 → stall released after 16 ACCESS cycles, bus_err pulse, wb_en_out=0.
5. reset=0 in the second ACCESS cycle → dmem_req drops immediately, all outputs 0, state IDLE; next LW after release completes normally.
6. MEM_MISALIGN_TRAP_EN: LW at 0x101 → misalign_err pulse, no dmem_req, wb_en_out=0. Undefined: LW at 0x101 → be=1111, dmem_addr=0x100.
